// File: rtl/sic1_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sic1_pkg                                                             |
// | Shared types and constants for the SIC-1 memory arbiter.             |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package sic1_pkg;
    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 8;
    localparam int REQ_CPU  = 0;
    localparam int REQ_HOST = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DATA  = 2'd2
    } arb_state_t;
endpackage
`default_nettype wire

// File: rtl/sic1_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sic1_rr_pick                                                         |
// | Two-way combinational picker returning a one-hot winner.             |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module sic1_rr_pick
    import sic1_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_host,
    input  logic       host_first,
    output logic [1:0] win
);
    always_comb begin
        win = req;
        // On a conflict the host wins under fixed priority, or when the CPU had the last grant
        if (req[REQ_CPU] && req[REQ_HOST]) begin
            win = 2'b00;
            if (host_first || !last_host) begin
                win[REQ_HOST] = 1'b1;
            end else begin
                win[REQ_CPU] = 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/sic1_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sic1_mem_arbiter                                                     |
// | Shares the 256-byte SIC-1 memory between the CPU core and host port. |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module sic1_mem_arbiter
    import sic1_pkg::*;
#(
    parameter bit HOST_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic [7:0]        conflicts
);
    arb_state_t r_state;
    arb_state_t w_state_next;
    logic [1:0] w_req;
    logic [1:0] w_win;
    logic       w_arb;
    logic       w_both;
    // Last winner doubles as the owner of the access currently in GRANT/DATA
    logic       r_last_host;
    logic       r_we;

    assign w_req[REQ_CPU]  = cpu_req;
    assign w_req[REQ_HOST] = host_req;
    assign w_arb  = (r_state != ST_GRANT) && (|w_req);
    assign w_both = cpu_req && host_req;

    sic1_rr_pick u_pick (
        .req        (w_req),
        .last_host  (r_last_host),
        .host_first (HOST_FIRST),
        .win        (w_win)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = ST_IDLE;
        cpu_gnt      = 1'b0;
        host_gnt     = 1'b0;
        cpu_rvalid   = 1'b0;
        host_rvalid  = 1'b0;
        mem_wr_en    = 1'b0;
        case (r_state)
            ST_GRANT: begin
                w_state_next = ST_DATA;
                cpu_gnt      = !r_last_host;
                host_gnt     = r_last_host;
                mem_wr_en    = r_we;
            end
            ST_DATA: begin
                w_state_next = w_arb ? ST_GRANT : ST_IDLE;
                cpu_rvalid   = !r_we && !r_last_host;
                host_rvalid  = !r_we && r_last_host;
            end
            default: begin
                w_state_next = w_arb ? ST_GRANT : ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_host <= 1'b1;
            r_we        <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            rdata       <= '0;
            conflicts   <= '0;
        end else begin
            if (w_arb) begin
                r_last_host <= w_win[REQ_HOST];
                r_we        <= w_win[REQ_CPU] ? cpu_we    : host_we;
                mem_addr    <= w_win[REQ_CPU] ? cpu_addr  : host_addr;
                mem_data_in <= w_win[REQ_CPU] ? cpu_wdata : host_wdata;
                if (w_both && (conflicts != 8'hFF)) begin
                    conflicts <= conflicts + 8'd1;
                end
            end
            if ((r_state == ST_GRANT) && !r_we) begin
                rdata <= mem_data_out;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_sic1_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sic1_mem_arbiter                                                  |
// | Two arbiters (round-robin, host-first) against a transaction model.  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_sic1_mem_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] cpu_req, cpu_we, host_req, host_we;
    logic [7:0] cpu_addr [2], cpu_wdata [2], host_addr [2], host_wdata [2];
    logic [1:0] cpu_gnt, cpu_rvalid, host_gnt, host_rvalid, mem_wr_en;
    logic [7:0] rdata [2], mem_addr [2], mem_data_in [2], mem_data_out [2], conflicts [2];
    logic [7:0] mem [2][256];
    bit         mem_init_done;
    int         n_cmp = 0;
    int         n_fail = 0;

    // Model: access in GRANT this cycle (g_*), access in DATA this cycle (d_*)
    bit         m_g_valid [2], m_g_host [2], m_g_we [2];
    bit         m_d_valid [2], m_d_host [2], m_d_we [2];
    bit         m_last_host [2];
    logic [7:0] m_g_addr [2], m_g_wdata [2], m_rdata [2], m_maddr [2], m_mdin [2];
    int         m_conf [2];
    logic [7:0] m_mem [2][256];

    logic [1:0] s_cpu_gnt, s_host_gnt, s_cpu_rvalid, s_host_rvalid, s_wr;
    logic [7:0] s_rdata [2], s_conf [2];

    always #5 clk = ~clk;

    sic1_mem_arbiter #(.HOST_FIRST(1'b0)) u_dut_rr (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]),
        .cpu_gnt(cpu_gnt[0]), .cpu_rvalid(cpu_rvalid[0]),
        .host_req(host_req[0]), .host_we(host_we[0]), .host_addr(host_addr[0]), .host_wdata(host_wdata[0]),
        .host_gnt(host_gnt[0]), .host_rvalid(host_rvalid[0]),
        .rdata(rdata[0]), .mem_addr(mem_addr[0]), .mem_wr_en(mem_wr_en[0]),
        .mem_data_in(mem_data_in[0]), .mem_data_out(mem_data_out[0]), .conflicts(conflicts[0])
    );

    sic1_mem_arbiter #(.HOST_FIRST(1'b1)) u_dut_fp (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]),
        .cpu_gnt(cpu_gnt[1]), .cpu_rvalid(cpu_rvalid[1]),
        .host_req(host_req[1]), .host_we(host_we[1]), .host_addr(host_addr[1]), .host_wdata(host_wdata[1]),
        .host_gnt(host_gnt[1]), .host_rvalid(host_rvalid[1]),
        .rdata(rdata[1]), .mem_addr(mem_addr[1]), .mem_wr_en(mem_wr_en[1]),
        .mem_data_in(mem_data_in[1]), .mem_data_out(mem_data_out[1]), .conflicts(conflicts[1])
    );

    assign mem_data_out[0] = mem[0][mem_addr[0]];
    assign mem_data_out[1] = mem[1][mem_addr[1]];

    function automatic logic [7:0] init_byte(input logic [7:0] a);
        if (a == 8'h10) return 8'h5A;
        if (a == 8'h20) return 8'h11;
        return a * 8'd7 + 8'd3;
    endfunction

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int d = 0; d < 2; d++)
                for (int a = 0; a < 256; a++) mem[d][a] <= init_byte(a[7:0]);
            mem_init_done <= 1'b1;
        end else begin
            for (int d = 0; d < 2; d++)
                if (mem_wr_en[d]) mem[d][mem_addr[d]] <= mem_data_in[d];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset(input int d);
        m_g_valid[d] = 1'b0; m_d_valid[d] = 1'b0; m_last_host[d] = 1'b1;
        m_rdata[d] = 8'h00; m_maddr[d] = 8'h00; m_mdin[d] = 8'h00; m_conf[d] = 0;
    endfunction

    function automatic void model_step(input int d);
        bit host_wins;
        if (m_g_valid[d]) begin
            if (m_g_we[d]) m_mem[d][m_g_addr[d]] = m_g_wdata[d];
            else           m_rdata[d] = m_mem[d][m_g_addr[d]];
            m_d_valid[d] = 1'b1; m_d_host[d] = m_g_host[d]; m_d_we[d] = m_g_we[d];
            m_g_valid[d] = 1'b0;
        end else begin
            m_d_valid[d] = 1'b0;
            if (cpu_req[d] || host_req[d]) begin
                if (cpu_req[d] && host_req[d]) begin
                    m_conf[d]++;
                    // instance 1 is the host-first arbiter
                    host_wins = (d == 1) || !m_last_host[d];
                end else begin
                    host_wins = host_req[d];
                end
                m_last_host[d] = host_wins;
                m_g_valid[d] = 1'b1;
                m_g_host[d]  = host_wins;
                m_g_we[d]    = host_wins ? host_we[d]    : cpu_we[d];
                m_g_addr[d]  = host_wins ? host_addr[d]  : cpu_addr[d];
                m_g_wdata[d] = host_wins ? host_wdata[d] : cpu_wdata[d];
                m_maddr[d]   = m_g_addr[d];
                m_mdin[d]    = m_g_wdata[d];
            end
        end
    endfunction

    task automatic check_model(input int d);
        chk($sformatf("d%0d.cpu_gnt", d),     cpu_gnt[d],     m_g_valid[d] && !m_g_host[d]);
        chk($sformatf("d%0d.host_gnt", d),    host_gnt[d],    m_g_valid[d] && m_g_host[d]);
        chk($sformatf("d%0d.mem_wr_en", d),   mem_wr_en[d],   m_g_valid[d] && m_g_we[d]);
        chk($sformatf("d%0d.cpu_rvalid", d),  cpu_rvalid[d],  m_d_valid[d] && !m_d_we[d] && !m_d_host[d]);
        chk($sformatf("d%0d.host_rvalid", d), host_rvalid[d], m_d_valid[d] && !m_d_we[d] && m_d_host[d]);
        chk($sformatf("d%0d.rdata", d),       rdata[d],       m_rdata[d]);
        chk($sformatf("d%0d.mem_addr", d),    mem_addr[d],    m_maddr[d]);
        chk($sformatf("d%0d.mem_data_in", d), mem_data_in[d], m_mdin[d]);
        chk($sformatf("d%0d.conflicts", d),   conflicts[d],   (m_conf[d] > 255) ? 255 : m_conf[d]);
    endtask

    task automatic cycle();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) model_reset(d);
            check_model(d);
            s_cpu_gnt[d] = cpu_gnt[d]; s_host_gnt[d] = host_gnt[d];
            s_cpu_rvalid[d] = cpu_rvalid[d]; s_host_rvalid[d] = host_rvalid[d];
            s_wr[d] = mem_wr_en[d]; s_rdata[d] = rdata[d]; s_conf[d] = conflicts[d];
            if (rst_n) model_step(d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cpu(input logic req, input logic we, input logic [7:0] addr, input logic [7:0] wd);
        for (int d = 0; d < 2; d++) begin
            cpu_req[d] = req; cpu_we[d] = we; cpu_addr[d] = addr; cpu_wdata[d] = wd;
        end
    endtask

    task automatic drive_host(input logic req, input logic we, input logic [7:0] addr, input logic [7:0] wd);
        for (int d = 0; d < 2; d++) begin
            host_req[d] = req; host_we[d] = we; host_addr[d] = addr; host_wdata[d] = wd;
        end
    endtask

    function automatic logic [7:0] rand_addr();
        return ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
    endfunction

    // Requests are held through GRANT and may be withdrawn while still waiting
    task automatic rand_drive();
        for (int d = 0; d < 2; d++) begin
            if (!(m_g_valid[d] && !m_g_host[d])) begin
                if (!(cpu_req[d] && !(m_d_valid[d] && !m_d_host[d]) && $urandom_range(0, 7) != 0)) begin
                    cpu_req[d] = 1'($urandom_range(0, 1)); cpu_we[d] = 1'($urandom_range(0, 1));
                    cpu_addr[d] = rand_addr(); cpu_wdata[d] = 8'($urandom);
                end
            end
            if (!(m_g_valid[d] && m_g_host[d])) begin
                if (!(host_req[d] && !(m_d_valid[d] && m_d_host[d]) && $urandom_range(0, 7) != 0)) begin
                    host_req[d] = 1'($urandom_range(0, 1)); host_we[d] = 1'($urandom_range(0, 1));
                    host_addr[d] = rand_addr(); host_wdata[d] = 8'($urandom);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive_cpu(1'b0, 1'b0, 8'h00, 8'h00);
        drive_host(1'b0, 1'b0, 8'h00, 8'h00);
        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < 256; a++) m_mem[d][a] = init_byte(a[7:0]);
            model_reset(d);
        end
        cycle();
        cycle();
        chk("reset.conflicts", s_conf[0], 32'h0);
        chk("reset.rdata", s_rdata[1], 32'h0);
        rst_n = 1'b1;
        cycle();

        // Single CPU read of 0x10
        drive_cpu(1'b1, 1'b0, 8'h10, 8'h00);
        cycle();
        cycle();
        chk("t1.cpu_gnt", s_cpu_gnt[0], 32'h1);
        chk("t1.host_gnt", s_host_gnt[0], 32'h0);
        drive_cpu(1'b0, 1'b0, 8'h00, 8'h00);
        cycle();
        chk("t1.cpu_rvalid", s_cpu_rvalid[0], 32'h1);
        chk("t1.rdata", s_rdata[0], 32'h5A);
        chk("t1.host_rvalid", s_host_rvalid[0], 32'h0);
        cycle();

        // Host writes 0xC3 to 0xFF, CPU reads it back
        drive_host(1'b1, 1'b1, 8'hFF, 8'hC3);
        cycle();
        cycle();
        chk("t2.wr_en_grant", s_wr[0], 32'h1);
        drive_host(1'b0, 1'b0, 8'h00, 8'h00);
        drive_cpu(1'b1, 1'b0, 8'hFF, 8'h00);
        cycle();
        chk("t2.wr_en_after", s_wr[0], 32'h0);
        cycle();
        drive_cpu(1'b0, 1'b0, 8'h00, 8'h00);
        cycle();
        chk("t2.cpu_rvalid", s_cpu_rvalid[0], 32'h1);
        chk("t2.rdata", s_rdata[0], 32'hC3);

        // Held conflict: round-robin alternates, host-first always picks host
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        drive_cpu(1'b1, 1'b0, 8'h01, 8'h00);
        drive_host(1'b1, 1'b0, 8'h02, 8'h00);
        for (int k = 1; k <= 8; k++) begin
            cycle();
            if (k % 2 == 0) begin
                chk($sformatf("t3.rr_cpu_k%0d", k), s_cpu_gnt[0], 32'(k % 4 == 2));
                chk($sformatf("t3.rr_host_k%0d", k), s_host_gnt[0], 32'(k % 4 == 0));
                chk($sformatf("t4.fp_host_k%0d", k), s_host_gnt[1], 32'h1);
                chk($sformatf("t4.fp_cpu_k%0d", k), s_cpu_gnt[1], 32'h0);
            end
        end
        chk("t3.conflicts", s_conf[0], 32'h4);
        drive_host(1'b0, 1'b0, 8'h00, 8'h00);
        cycle();
        cycle();
        chk("t4.cpu_after_drop", s_cpu_gnt[1], 32'h1);
        drive_cpu(1'b0, 1'b0, 8'h00, 8'h00);
        cycle();
        cycle();

        // Saturation of the conflict counter
        drive_cpu(1'b1, 1'b0, 8'h03, 8'h00);
        drive_host(1'b1, 1'b0, 8'h04, 8'h00);
        repeat (620) cycle();
        chk("t5.sat_rr", s_conf[0], 32'hFF);
        chk("t5.sat_fp", s_conf[1], 32'hFF);
        drive_cpu(1'b0, 1'b0, 8'h00, 8'h00);
        drive_host(1'b0, 1'b0, 8'h00, 8'h00);
        cycle();
        cycle();

        // Randomized traffic against the model
        repeat (400) begin
            rand_drive();
            cycle();
        end
        drive_cpu(1'b0, 1'b0, 8'h00, 8'h00);
        drive_host(1'b0, 1'b0, 8'h00, 8'h00);
        repeat (3) cycle();

        // Asynchronous reset in the GRANT cycle of a host write
        drive_host(1'b1, 1'b1, 8'h20, 8'h99);
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6.wr_en_rr", mem_wr_en[0], 32'h0);
        chk("t6.wr_en_fp", mem_wr_en[1], 32'h0);
        chk("t6.host_gnt", host_gnt[0], 32'h0);
        drive_host(1'b0, 1'b0, 8'h00, 8'h00);
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("t6.mem20_rr", mem[0][8'h20], 32'h11);
        chk("t6.mem20_fp", mem[1][8'h20], 32'h11);
        drive_cpu(1'b1, 1'b0, 8'h20, 8'h00);
        cycle();
        cycle();
        drive_cpu(1'b0, 1'b0, 8'h00, 8'h00);
        cycle();
        chk("t6.rdata", s_rdata[0], 32'h11);
        cycle();

        for (int d = 0; d < 2; d++)
            for (int a = 0; a < 256; a++)
                chk($sformatf("mem%0d[%0h]", d, a), mem[d][a], m_mem[d][a]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
